tpm_partner: RTL and testbench

//  One party of a tree-parity-machine (TPM) neural key exchange. It holds K*N signed weights,

---
 rtl/tpm_partner.sv | 193 +++++++++++++++++++
 tb/tb_tpm_partner.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpm_partner.sv
// Tree-parity-machine key-exchange party: K hidden units of N bounded signed weights.
// A sequencer drives init/compute/learn through ctrl and watches dirty for completion.
module tpm_partner #(
   parameter int K  = 2,
   parameter int N  = 3,
   parameter int L  = 3,
   parameter int WW = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [K*N-1:0]       feed,
   input  logic                 out_other,
   input  logic [2:0]           ctrl,
   input  logic [2:0]           partner_no,
   output logic                 out,
   output logic [K-1:0]         deltas,
   output logic                 dirty,
   output logic [K*N*WW-1:0]    weights
);
   localparam int KN  = K * N;
   localparam int IW  = (KN > 1) ? $clog2(KN + 1) : 1;
   localparam int UW  = (K > 1) ? $clog2(K + 1) : 1;
   localparam int PW  = (N > 1) ? $clog2(N) : 1;
   localparam int AW0 = $clog2(N * L) + 2;
   localparam int AW  = (AW0 > WW) ? AW0 : WW + 1;

   localparam logic [2:0] CMD_INIT  = 3'b001;
   localparam logic [2:0] CMD_COMP  = 3'b010;
   localparam logic [2:0] CMD_LEARN = 3'b100;

   localparam logic signed [WW-1:0] W_MAX = WW'(L);
   localparam logic signed [WW-1:0] W_MIN = -W_MAX;
   localparam logic signed [WW-1:0] W_ONE = WW'(1);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_MAC} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [2:0]            r_ctrl_q;
   logic [12:0]           r_lfsr;
   logic [IW-1:0]         r_idx;
   logic [UW-1:0]         r_unit;
   logic [PW-1:0]         r_pos;
   logic [KN-1:0]         r_feed;
   logic signed [WW-1:0]  r_w [KN];
   logic signed [AW-1:0]  r_acc [K];
   logic                  r_out;
   logic [K-1:0]          r_deltas;

   logic                  w_busy;
   logic                  w_cmd_new;
   logic                  w_accept;
   logic                  w_start_init;
   logic                  w_start_comp;
   logic                  w_start_learn;
   logic                  w_init_wr;
   logic                  w_mac_last;
   logic                  w_agree;
   logic [12:0]           w_seed;
   logic [12:0]           w_lfsr_src;
   logic [12:0]           w_lfsr_step;
   logic [2:0]            w_rnd;
   logic signed [WW-1:0]  w_new_w;
   logic [IW-1:0]         w_init_idx;
   logic signed [WW-1:0]  w_cur_w;
   logic signed [AW-1:0]  w_cur_ext;
   logic signed [AW-1:0]  w_prod;
   logic signed [AW-1:0]  w_acc_next [K];
   logic [K-1:0]          w_sigma;
   logic                  w_tau;
   logic [KN-1:0]         w_learn_en;
   logic signed [WW-1:0]  w_learn_w [KN];

   // Fibonacci LFSR, x^13 + x^4 + x^3 + x + 1, shifting toward the MSB.
   function automatic logic [12:0] lfsr_step(input logic [12:0] s);
      return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
   endfunction

   assign w_busy        = (r_state != S_IDLE);
   assign w_cmd_new     = (ctrl != r_ctrl_q);
   assign w_accept      = w_cmd_new & ~w_busy;
   assign w_start_init  = w_accept & (ctrl == CMD_INIT);
   assign w_start_comp  = w_accept & (ctrl == CMD_COMP);
   assign w_start_learn = w_accept & (ctrl == CMD_LEARN);

   // Combinational so the sequencer sees busy on the very edge after it issues a command.
   assign dirty = rst & (w_busy | (w_cmd_new & ((ctrl == CMD_INIT) | (ctrl == CMD_COMP))));

   assign w_seed      = 13'h1ACE ^ {10'b0, partner_no};
   assign w_lfsr_src  = (r_state == S_INIT) ? r_lfsr : ((w_seed == '0) ? 13'd1 : w_seed);
   assign w_lfsr_step = lfsr_step(w_lfsr_src);
   assign w_rnd       = (w_lfsr_step[2:0] == 3'b100) ? 3'b101 : w_lfsr_step[2:0];
   assign w_new_w     = {{(WW-3){w_rnd[2]}}, w_rnd};
   assign w_init_wr   = w_start_init | (r_state == S_INIT);
   assign w_init_idx  = (r_state == S_INIT) ? r_idx : '0;

   assign w_cur_w    = r_w[r_idx[$clog2(KN)-1:0]];
   assign w_cur_ext  = {{(AW-WW){w_cur_w[WW-1]}}, w_cur_w};
   assign w_prod     = r_feed[r_idx[$clog2(KN)-1:0]] ? w_cur_ext : -w_cur_ext;
   assign w_mac_last = (r_idx == IW'(KN - 1));

   generate
      for (genvar gi = 0; gi < K; gi++) begin : g_unit
         assign w_acc_next[gi] = r_acc[gi] + ((r_unit == UW'(gi)) ? w_prod : '0);
         // h = 0 counts as -1
         assign w_sigma[gi]    = ~w_acc_next[gi][AW-1] & (w_acc_next[gi] != '0);
      end
   endgenerate

   // tau = product of sigmas: +1 when an even number of units voted -1
   assign w_tau   = ~(^(~w_sigma));
   assign w_agree = (r_out == out_other);

   generate
      for (genvar gi = 0; gi < KN; gi++) begin : g_weight
         assign w_learn_en[gi] = w_start_learn & w_agree & (r_deltas[gi / N] == r_out);
         assign w_learn_w[gi]  = (r_feed[gi] == r_out)
                                ? ((r_w[gi] >= W_MAX) ? W_MAX : r_w[gi] + W_ONE)
                                : ((r_w[gi] <= W_MIN) ? W_MIN : r_w[gi] - W_ONE);
         assign weights[gi*WW +: WW] = r_w[gi];
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_init)      w_state_next = S_INIT;
            else if (w_start_comp) w_state_next = S_MAC;
         end
         S_INIT:  if (r_idx == IW'(KN - 1)) w_state_next = S_IDLE;
         S_MAC:   if (w_mac_last)           w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_ctrl_q <= 3'b000;
         r_lfsr   <= 13'd1;
         r_idx    <= '0;
         r_unit   <= '0;
         r_pos    <= '0;
         r_feed   <= '0;
         r_out    <= 1'b0;
         r_deltas <= '0;
         for (int i = 0; i < KN; i++) r_w[i] <= '0;
         for (int k = 0; k < K; k++)  r_acc[k] <= '0;
      end else begin
         r_state  <= w_state_next;
         r_ctrl_q <= ctrl;

         // Weight 0 is drawn on the accepting edge so init spans exactly K*N cycles.
         if (w_init_wr) begin
            r_lfsr <= w_lfsr_step;
            r_idx  <= w_init_idx + IW'(1);
         end

         if (w_start_comp) begin
            r_feed <= feed;
            r_idx  <= '0;
            r_unit <= '0;
            r_pos  <= '0;
            for (int k = 0; k < K; k++) r_acc[k] <= '0;
         end

         if (r_state == S_MAC) begin
            for (int k = 0; k < K; k++) r_acc[k] <= w_acc_next[k];
            r_idx <= r_idx + IW'(1);
            if (r_pos == PW'(N - 1)) begin
               r_pos  <= '0;
               r_unit <= r_unit + UW'(1);
            end else begin
               r_pos  <= r_pos + PW'(1);
            end
            if (w_mac_last) begin
               r_out    <= w_tau;
               r_deltas <= w_sigma;
            end
         end

         for (int i = 0; i < KN; i++) begin
            if (w_init_wr && (w_init_idx == IW'(i))) r_w[i] <= w_new_w;
            else if (w_learn_en[i])                  r_w[i] <= w_learn_w[i];
         end
      end
   end

   assign out    = r_out;
   assign deltas = r_deltas;

endmodule

// File: tb/tb_tpm_partner.sv
// Directed bench for tpm_partner: reference model feeds a scoreboard of expected
// out/deltas/weights, checked when each command completes; ends with a two-party sync run.
module tb_tpm_partner;
   localparam int K  = 2;
   localparam int N  = 3;
   localparam int KN = K * N;
   localparam int WW = 4;
   localparam logic [2:0] C_IDLE  = 3'b000;
   localparam logic [2:0] C_INIT  = 3'b001;
   localparam logic [2:0] C_COMP  = 3'b010;
   localparam logic [2:0] C_LEARN = 3'b100;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [KN-1:0]    feed = '0;
   logic [2:0]       ctrl = 3'b000;
   logic             other_sel = 1'b0;
   logic             tb_other = 1'b0;
   logic             a_other;
   logic             a_out, b_out, a_dirty, b_dirty;
   logic [K-1:0]     a_del, b_del;
   logic [KN*WW-1:0] a_w, b_w;

   assign a_other = other_sel ? b_out : tb_other;

   tpm_partner #(.K(K), .N(N), .L(3), .WW(WW)) dut_a (
      .clk(clk), .rst(rst), .feed(feed), .out_other(a_other), .ctrl(ctrl),
      .partner_no(3'd1), .out(a_out), .deltas(a_del), .dirty(a_dirty), .weights(a_w));

   tpm_partner #(.K(K), .N(N), .L(3), .WW(WW)) dut_b (
      .clk(clk), .rst(rst), .feed(feed), .out_other(a_out), .ctrl(ctrl),
      .partner_no(3'd2), .out(b_out), .deltas(b_del), .dirty(b_dirty), .weights(b_w));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int            mw [2][KN];
   logic          mout [2];
   logic [K-1:0]  mdel [2];
   logic [KN-1:0] mfeed [2];

   typedef struct {
      logic             o;
      logic [K-1:0]     d;
      logic [KN*WW-1:0] w;
   } exp_t;
   exp_t qa[$];

   function automatic logic [12:0] ref_lfsr(input logic [12:0] s);
      return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < KN; i++) mw[p][i] = 0;
         mout[p] = 1'b0; mdel[p] = '0; mfeed[p] = '0;
      end
   endtask

   task automatic model_init(input int p, input logic [2:0] pno);
      logic [12:0] s;
      int v;
      s = 13'h1ACE ^ {10'b0, pno};
      if (s == 13'd0) s = 13'd1;
      for (int i = 0; i < KN; i++) begin
         s = ref_lfsr(s);
         v = int'(s[2:0]);
         if (v >= 4) v = v - 8;
         if (v == -4) v = -3;
         mw[p][i] = v;
      end
   endtask

   task automatic model_compute(input int p, input logic [KN-1:0] f);
      int h [K];
      int neg;
      mfeed[p] = f;
      for (int k = 0; k < K; k++) h[k] = 0;
      for (int i = 0; i < KN; i++) h[i / N] += (f[i] ? 1 : -1) * mw[p][i];
      neg = 0;
      for (int k = 0; k < K; k++) begin
         mdel[p][k] = (h[k] > 0);
         if (h[k] <= 0) neg++;
      end
      mout[p] = ((neg % 2) == 0);
   endtask

   task automatic model_learn(input int p, input logic other);
      if (mout[p] == other) begin
         for (int i = 0; i < KN; i++) begin
            if (mdel[p][i / N] == mout[p]) begin
               mw[p][i] += (mfeed[p][i] == mout[p]) ? 1 : -1;
               if (mw[p][i] > 3)  mw[p][i] = 3;
               if (mw[p][i] < -3) mw[p][i] = -3;
            end
         end
      end
   endtask

   function automatic logic [KN*WW-1:0] pack_w(input int p);
      logic [KN*WW-1:0] r;
      r = '0;
      for (int i = 0; i < KN; i++) r[i*WW +: WW] = WW'(mw[p][i]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push();
      exp_t e;
      e.o = mout[0];
      e.d = mdel[0];
      e.w = pack_w(0);
      qa.push_back(e);
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      if (qa.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = qa.pop_front();
         chk({tag, "_out"}, {31'd0, a_out}, {31'd0, e.o});
         chk({tag, "_deltas"}, {30'd0, a_del}, {30'd0, e.d});
         chk({tag, "_weights"}, {8'd0, a_w}, {8'd0, e.w});
         $display("[TB] %s out=%0b deltas=%b weights=%h", tag, a_out, a_del, a_w);
      end
   endtask

   task automatic cmd(input logic [2:0] c);
      @(negedge clk);
      ctrl = C_IDLE;
      @(negedge clk);
      ctrl = c;
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (a_dirty === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   function automatic logic in_range(input logic [KN*WW-1:0] w);
      logic [WW-1:0] f;
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < KN; i++) begin
         f = w[i*WW +: WW];
         if ($signed(f) > 3 || $signed(f) < -3) ok = 1'b0;
      end
      return ok;
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int run;
      int iters;
      int tmo;
      logic synced;

      // Reset held across several edges
      model_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_out", {31'd0, a_out}, 32'd0);
      chk("reset_deltas", {30'd0, a_del}, 32'd0);
      chk("reset_dirty", {31'd0, a_dirty}, 32'd0);
      chk("reset_weights", {8'd0, a_w}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Init both parties
      cmd(C_INIT);
      model_init(0, 3'd1);
      model_init(1, 3'd2);
      sb_push();
      wait_done(n);
      chk("init_dirty_cycles", n, 32'd6);
      sb_check("init_a");
      chk("init_b_weights", {8'd0, b_w}, {8'd0, pack_w(1)});
      chk("init_a_range", {31'd0, in_range(a_w)}, 32'd1);
      chk("init_b_range", {31'd0, in_range(b_w)}, 32'd1);
      chk("init_sets_differ", {31'd0, (a_w !== b_w)}, 32'd1);

      cmd(C_INIT);
      sb_push();
      wait_done(n);
      sb_check("reinit_a");

      // Compute
      feed = 6'b000111;
      cmd(C_COMP);
      model_compute(0, feed);
      model_compute(1, feed);
      sb_push();
      wait_done(n);
      chk("comp_dirty_cycles", n, 32'd7);
      sb_check("comp_a");

      // Learn with agreement, then disagreement, then repeat until saturation
      tb_other = mout[0];
      cmd(C_LEARN);
      chk("learn_dirty", {31'd0, a_dirty}, 32'd0);
      model_learn(0, tb_other);
      sb_push();
      @(negedge clk); #1;
      sb_check("learn_agree");

      tb_other = ~mout[0];
      cmd(C_LEARN);
      model_learn(0, tb_other);
      sb_push();
      @(negedge clk); #1;
      sb_check("learn_disagree");

      tb_other = mout[0];
      for (int r = 0; r < 6; r++) begin
         cmd(C_LEARN);
         model_learn(0, tb_other);
         sb_push();
         @(negedge clk); #1;
         sb_check("learn_sat");
      end

      // Holding the same command must not re-trigger it
      repeat (3) @(negedge clk);
      #1;
      chk("learn_no_retrigger", {8'd0, a_w}, {8'd0, pack_w(0)});

      // Two-party synchronisation
      other_sel = 1'b1;
      cmd(C_INIT);
      model_init(0, 3'd1);
      model_init(1, 3'd2);
      wait_done(n);
      run = 0;
      tmo = 0;
      synced = 1'b0;
      iters = 0;
      while (!synced && iters < 3000) begin
         iters++;
         feed = KN'($urandom_range(0, (1 << KN) - 1));
         cmd(C_COMP);
         model_compute(0, feed);
         model_compute(1, feed);
         wait_done(n);
         if (n >= 40) tmo++;
         if (a_out == b_out) begin
            cmd(C_LEARN);
            model_learn(0, mout[1]);
            model_learn(1, mout[0]);
            @(negedge clk); #1;
            run++;
         end else begin
            run = 0;
         end
         if (run >= 10 && a_w == b_w) synced = 1'b1;
      end
      $display("[TB] sync iterations=%0d", iters);
      chk("sync_timeouts", tmo, 32'd0);
      chk("sync_reached", {31'd0, synced}, 32'd1);
      chk("sync_a_model", {8'd0, a_w}, {8'd0, pack_w(0)});
      chk("sync_b_model", {8'd0, b_w}, {8'd0, pack_w(1)});
      chk("sync_weights_equal", {8'd0, a_w}, {8'd0, b_w});
      other_sel = 1'b0;

      // Reset in the middle of a compute
      feed = 6'b101100;
      cmd(C_COMP);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ctrl = C_IDLE;
      #1;
      model_reset();
      chk("midreset_out", {31'd0, a_out}, 32'd0);
      chk("midreset_deltas", {30'd0, a_del}, 32'd0);
      chk("midreset_dirty", {31'd0, a_dirty}, 32'd0);
      chk("midreset_weights", {8'd0, a_w}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      cmd(C_INIT);
      model_init(0, 3'd1);
      sb_push();
      wait_done(n);
      chk("post_init_dirty_cycles", n, 32'd6);
      sb_check("post_init_a");

      feed = 6'b110010;
      cmd(C_COMP);
      model_compute(0, feed);
      sb_push();
      wait_done(n);
      chk("post_comp_dirty_cycles", n, 32'd7);
      sb_check("post_comp_a");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
